// File: rtl/regfile_wb_sched_pkg.sv
// Shared constants and arbiter state encoding for the write-back scheduler.
package regfile_wb_sched_pkg;
   localparam int NUM_REGS   = 32;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;

   typedef enum logic {
      MEM_PRI   = 1'b0,
      ALU_FORCE = 1'b1
   } arb_state_e;
endpackage

// File: rtl/regfile_wb_sched_scoreboard.sv
// Busy-mask scoreboard: pending-destination tracking plus issue stall/bypass compare.
// Optional RF_WB_BYPASS_EN exposes source-hit flags against the in-flight write.
module rf_scoreboard
   import regfile_wb_sched_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                issue_valid,
   input  logic                issue_wr,
   input  logic [ADDR_W-1:0]   issue_rd,
   input  logic [ADDR_W-1:0]   issue_rs1,
   input  logic [ADDR_W-1:0]   issue_rs2,
   input  logic                clr_en,
   input  logic [ADDR_W-1:0]   clr_rd,
   output logic                stall,
   output logic [NUM_REGS-1:0] busy_mask
`ifdef RF_WB_BYPASS_EN
   ,
   output logic                byp1_hit,
   output logic                byp2_hit
`endif
);
   logic [NUM_REGS-1:0] busy_q, busy_d, set_vec, clr_vec;
   logic                src1_haz, src2_haz, dst_haz, set_en;

   always_comb begin
      src1_haz = busy_q[issue_rs1] & (issue_rs1 != '0);
      src2_haz = busy_q[issue_rs2] & (issue_rs2 != '0);
`ifdef RF_WB_BYPASS_EN
      byp1_hit = clr_en & (clr_rd == issue_rs1) & (clr_rd != '0);
      byp2_hit = clr_en & (clr_rd == issue_rs2) & (clr_rd != '0);
      src1_haz = src1_haz & ~byp1_hit;
      src2_haz = src2_haz & ~byp2_hit;
`endif
      // WAW on the destination is never bypassed: the older write must land first.
      dst_haz = issue_wr & busy_q[issue_rd] & (issue_rd != '0);
      stall   = issue_valid & (src1_haz | src2_haz | dst_haz);
      set_en  = issue_valid & ~stall & issue_wr & (issue_rd != '0);

      set_vec = '0;
      clr_vec = '0;
      if (set_en) set_vec[issue_rd] = 1'b1;
      if (clr_en) clr_vec[clr_rd]   = 1'b1;
      busy_d    = (busy_q & ~clr_vec) | set_vec;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) busy_q <= '0;
      else      busy_q <= busy_d;
   end

   assign busy_mask = busy_q;
endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back arbiter (ALU vs load) with anti-starvation, registered RF write port and wb_err.
// Optional RF_WB_BYPASS_EN adds byp1_hit/byp2_hit/byp_data forwarding outputs.
module regfile_wb_sched
   import regfile_wb_sched_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int STARVE_MAX = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                issue_valid,
   input  logic                issue_wr,
   input  logic [ADDR_W-1:0]   issue_rd,
   input  logic [ADDR_W-1:0]   issue_rs1,
   input  logic [ADDR_W-1:0]   issue_rs2,
   output logic                stall,
   input  logic                alu_valid,
   input  logic [ADDR_W-1:0]   alu_rd,
   input  logic [DATA_W-1:0]   alu_data,
   output logic                alu_ready,
   input  logic                mem_valid,
   input  logic [ADDR_W-1:0]   mem_rd,
   input  logic [DATA_W-1:0]   mem_data,
   output logic                mem_ready,
   output logic                rf_we,
   output logic [ADDR_W-1:0]   rf_rd,
   output logic [DATA_W-1:0]   rf_data,
   output logic [NUM_REGS-1:0] busy_mask,
   output logic                wb_err
`ifdef RF_WB_BYPASS_EN
   ,
   output logic                byp1_hit,
   output logic                byp2_hit,
   output logic [DATA_W-1:0]   byp_data
`endif
);
   localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);

   arb_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic              mem_xfer, alu_xfer, xfer;
   logic [ADDR_W-1:0] sel_rd;
   logic [DATA_W-1:0] sel_data;
   logic              rf_we_q, rf_we_d, wb_err_q, wb_err_d;
   logic [ADDR_W-1:0] rf_rd_q;
   logic [DATA_W-1:0] rf_data_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_ready = 1'b0;
      alu_ready = 1'b0;
      cnt_inc   = cnt_q + 1'b1;
      case (state_q)
         MEM_PRI: begin
            mem_ready = 1'b1;
            alu_ready = ~mem_valid;
            if (alu_valid & mem_valid) begin
               if (cnt_inc >= STARVE_LIM) begin
                  state_d = ALU_FORCE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end else if (alu_valid) begin
               cnt_d = '0;
            end
         end
         // Single forced slot: exits whether the ALU takes it or has dropped valid.
         ALU_FORCE: begin
            alu_ready = 1'b1;
            state_d   = MEM_PRI;
            cnt_d     = '0;
         end
         default: begin
            state_d = MEM_PRI;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      mem_xfer = mem_valid & mem_ready;
      alu_xfer = alu_valid & alu_ready;
      xfer     = mem_xfer | alu_xfer;
      sel_rd   = mem_xfer ? mem_rd   : alu_rd;
      sel_data = mem_xfer ? mem_data : alu_data;
      // x0 writes still handshake but never reach the register file.
      rf_we_d  = xfer & (sel_rd != '0);
      wb_err_d = wb_err_q | (rf_we_d & ~busy_mask[sel_rd]);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= MEM_PRI;
         cnt_q     <= '0;
         rf_we_q   <= 1'b0;
         rf_rd_q   <= '0;
         rf_data_q <= '0;
         wb_err_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rf_we_q  <= rf_we_d;
         wb_err_q <= wb_err_d;
         if (rf_we_d) begin
            rf_rd_q   <= sel_rd;
            rf_data_q <= sel_data;
         end
      end
   end

   rf_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
      .clk        (clk),
      .rst        (rst),
      .issue_valid(issue_valid),
      .issue_wr   (issue_wr),
      .issue_rd   (issue_rd),
      .issue_rs1  (issue_rs1),
      .issue_rs2  (issue_rs2),
      .clr_en     (rf_we_q),
      .clr_rd     (rf_rd_q),
      .stall      (stall),
      .busy_mask  (busy_mask)
`ifdef RF_WB_BYPASS_EN
      ,
      .byp1_hit   (byp1_hit),
      .byp2_hit   (byp2_hit)
`endif
   );

   assign rf_we   = rf_we_q;
   assign rf_rd   = rf_rd_q;
   assign rf_data = rf_data_q;
   assign wb_err  = wb_err_q;
`ifdef RF_WB_BYPASS_EN
   assign byp_data = rf_data_q;
`endif
endmodule
